// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions: 640x480@60 constants and the per-axis total helper.
package vga_timing_pkg;

   // One axis of a raster: visible region followed by front porch, sync and back porch.
   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_timing_t;

   localparam int unsigned VGA_CNT_W    = 10;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;

   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   localparam bit          VGA_HS_POL   = 1'b0;
   localparam bit          VGA_VS_POL   = 1'b0;

   // Length of one axis period (pixels per line or lines per frame).
   function automatic int unsigned calc_total(input axis_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX counter with synchronous clear, increment enable and a wrap strobe.
module mod_counter #(
   parameter int unsigned W   = 10,
   parameter int unsigned MAX = 800
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clear,
   input  logic         i_inc,
   output logic [W-1:0] o_count,
   output logic [W-1:0] o_count_next,
   output logic         o_wrap
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);
   localparam logic [W-1:0] ONE  = W'(1);

   logic [W-1:0] r_count;
   logic [W-1:0] w_count_next;
   logic         w_at_last;

   assign w_at_last = (r_count == LAST);
   // Wrap fires on the tick that takes the count from MAX-1 back to 0.
   assign o_wrap    = i_inc & w_at_last;

   // Next count: clear dominates, then increment with wrap, else hold.
   always_comb begin
      w_count_next = r_count;
      if (i_clear) begin
         w_count_next = '0;
      end else if (i_inc) begin
         w_count_next = w_at_last ? '0 : r_count + ONE;
      end
   end

   // Count register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign o_count      = r_count;
   assign o_count_next = w_count_next;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, syncs, display enable,
// end-of-line and start-of-frame markers.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CNT_W    = VGA_CNT_W,
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter bit          HS_POL   = VGA_HS_POL,
   parameter bit          VS_POL   = VGA_VS_POL
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pix_en,
   input  logic             i_restart,
   output logic [CNT_W-1:0] o_h_count,
   output logic [CNT_W-1:0] o_v_count,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_de,
   output logic             o_line_end,
   output logic             o_frame_start
);

   localparam axis_timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
   localparam axis_timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
   localparam int unsigned  H_TOTAL = calc_total(H_TIM);
   localparam int unsigned  V_TOTAL = calc_total(V_TIM);

   if ((H_TOTAL == 0) || (H_TOTAL > (2 ** CNT_W))) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL=%0d does not fit CNT_W=%0d", H_TOTAL, CNT_W);
   end
   if ((V_TOTAL == 0) || (V_TOTAL > (2 ** CNT_W))) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL=%0d does not fit CNT_W=%0d", V_TOTAL, CNT_W);
   end

   // Sync windows are tested as (count - start) < len in CNT_W bits. A count below the
   // start wraps to at least 2**CNT_W - start >= TOTAL - start >= len, so it never matches,
   // and a window ending exactly at 2**CNT_W needs no end constant.
   localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0]   HS_LEN    = (CNT_W + 1)'(H_SYNC);
   localparam logic [CNT_W:0]   VS_LEN    = (CNT_W + 1)'(V_SYNC);
   localparam logic [CNT_W:0]   H_ACT_LIM = (CNT_W + 1)'(H_ACTIVE);
   localparam logic [CNT_W:0]   V_ACT_LIM = (CNT_W + 1)'(V_ACTIVE);

   // Reset leaves the counters at (0,0); the registered outputs start at the values that
   // position decodes to, so they stay aligned from the first clock.
   localparam bit HS_AT_ZERO = (H_SYNC != 0) && ((H_ACTIVE + H_FP) == 0);
   localparam bit VS_AT_ZERO = (V_SYNC != 0) && ((V_ACTIVE + V_FP) == 0);
   localparam bit DE_AT_ZERO = (H_ACTIVE != 0) && (V_ACTIVE != 0);

   logic [CNT_W-1:0] w_h_count;
   logic [CNT_W-1:0] w_v_count;
   logic [CNT_W-1:0] w_h_next;
   logic [CNT_W-1:0] w_v_next;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic [CNT_W-1:0] w_h_off;
   logic [CNT_W-1:0] w_v_off;
   logic             w_hs_act;
   logic             w_vs_act;
   logic             w_de_act;

   logic             r_hsync;
   logic             r_vsync;
   logic             r_de;
   logic             r_frame_start;

   mod_counter #(
      .W   (CNT_W),
      .MAX (H_TOTAL)
   ) u_h_cnt (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (i_restart),
      .i_inc        (i_pix_en),
      .o_count      (w_h_count),
      .o_count_next (w_h_next),
      .o_wrap       (w_h_wrap)
   );

   mod_counter #(
      .W   (CNT_W),
      .MAX (V_TOTAL)
   ) u_v_cnt (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (i_restart),
      .i_inc        (w_h_wrap),
      .o_count      (w_v_count),
      .o_count_next (w_v_next),
      .o_wrap       (w_v_wrap)
   );

   // Decode the next-state position so the registered outputs line up with the counts.
   always_comb begin
      w_h_off  = w_h_next - HS_START;
      w_v_off  = w_v_next - VS_START;
      w_hs_act = ({1'b0, w_h_off} < HS_LEN);
      w_vs_act = ({1'b0, w_v_off} < VS_LEN);
      w_de_act = ({1'b0, w_h_next} < H_ACT_LIM) && ({1'b0, w_v_next} < V_ACT_LIM);
   end

   // Registered syncs, display enable and frame marker.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hsync       <= HS_AT_ZERO ? HS_POL : ~HS_POL;
         r_vsync       <= VS_AT_ZERO ? VS_POL : ~VS_POL;
         r_de          <= DE_AT_ZERO;
         r_frame_start <= 1'b0;
      end else begin
         r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
         r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
         r_de          <= w_de_act;
         // v wrap already implies an h wrap, i.e. the natural return to (0,0).
         r_frame_start <= i_restart | w_v_wrap;
      end
   end

   assign o_h_count     = w_h_count;
   assign o_v_count     = w_v_count;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_de          = r_de;
   assign o_line_end    = w_h_wrap;
   assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default 640x480 instance and a small odd-shaped instance share
// stimulus; a position-based model predicts every output each cycle.
module tb_vga_timing_gen;

   // Big (default) geometry.
   localparam int B_HT = 800, B_HA = 640, B_HSS = 656, B_HSE = 752;
   localparam int B_VT = 525, B_VA = 480, B_VSS = 490, B_VSE = 492;
   // Small geometry: H 6/0/3/2, V 4/1/2/0, active-high hsync.
   localparam int S_HT = 11, S_HA = 6, S_HSS = 6, S_HSE = 9;
   localparam int S_VT = 7, S_VA = 4, S_VSS = 5, S_VSE = 7;

   logic       clk;
   logic       rst_n;
   logic       pix_en;
   logic       restart;

   logic [9:0] b_h, b_v;
   logic       b_hs, b_vs, b_de, b_le, b_fs;
   logic [3:0] s_h, s_v;
   logic       s_hs, s_vs, s_de, s_le, s_fs;

   int n_vec = 0;
   int n_err = 0;

   // Model state: linear position inside the frame plus the expected frame marker.
   int m_pos_b = 0, m_pos_s = 0;
   bit m_fs_b = 0, m_fs_s = 0;

   // Values captured at the last per-cycle check, for the multi-cycle scenarios.
   int last_h_b, last_hs_b, last_de_b, last_le_b;
   int last_v_s, last_vs_s, last_fs_s;

   vga_timing_gen u_big (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_pix_en      (pix_en),
      .i_restart     (restart),
      .o_h_count     (b_h),
      .o_v_count     (b_v),
      .o_hsync       (b_hs),
      .o_vsync       (b_vs),
      .o_de          (b_de),
      .o_line_end    (b_le),
      .o_frame_start (b_fs)
   );

   vga_timing_gen #(
      .CNT_W    (4),
      .H_ACTIVE (6),
      .H_FP     (0),
      .H_SYNC   (3),
      .H_BP     (2),
      .V_ACTIVE (4),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (0),
      .HS_POL   (1'b1),
      .VS_POL   (1'b0)
   ) u_small (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_pix_en      (pix_en),
      .i_restart     (restart),
      .o_h_count     (s_h),
      .o_v_count     (s_v),
      .o_hsync       (s_hs),
      .o_vsync       (s_vs),
      .o_de          (s_de),
      .o_line_end    (s_le),
      .o_frame_start (s_fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Derive every expected output of one instance from its frame position.
   task automatic check_cfg(input string tag, input int pos, input bit fs_exp, input bit pe,
                            input int ht, input int ha, input int hss, input int hse,
                            input int va, input int vss, input int vse,
                            input bit hpol, input bit vpol,
                            input logic [31:0] a_h, input logic [31:0] a_v,
                            input logic a_hs, input logic a_vs, input logic a_de,
                            input logic a_le, input logic a_fs);
      int h, v;
      bit hs_in, vs_in, de_e, le_e;
      h     = pos % ht;
      v     = pos / ht;
      hs_in = (h >= hss) && (h < hse);
      vs_in = (v >= vss) && (v < vse);
      de_e  = (h < ha) && (v < va);
      le_e  = pe && (h == ht - 1);
      cmp({tag, "_h"}, a_h, 32'(h));
      cmp({tag, "_v"}, a_v, 32'(v));
      cmp({tag, "_hsync"}, 32'(a_hs), 32'(hs_in ? hpol : !hpol));
      cmp({tag, "_vsync"}, 32'(a_vs), 32'(vs_in ? vpol : !vpol));
      cmp({tag, "_de"}, 32'(a_de), 32'(de_e));
      cmp({tag, "_line_end"}, 32'(a_le), 32'(le_e));
      cmp({tag, "_frame_start"}, 32'(a_fs), 32'(fs_exp));
   endtask

   task automatic check_all(input bit pe);
      check_cfg("big", m_pos_b, m_fs_b, pe, B_HT, B_HA, B_HSS, B_HSE, B_VA, B_VSS, B_VSE,
                1'b0, 1'b0, 32'(b_h), 32'(b_v), b_hs, b_vs, b_de, b_le, b_fs);
      check_cfg("small", m_pos_s, m_fs_s, pe, S_HT, S_HA, S_HSS, S_HSE, S_VA, S_VSS, S_VSE,
                1'b1, 1'b0, 32'(s_h), 32'(s_v), s_hs, s_vs, s_de, s_le, s_fs);
      last_h_b  = int'(b_h);
      last_hs_b = int'(b_hs);
      last_de_b = int'(b_de);
      last_le_b = int'(b_le);
      last_v_s  = int'(s_v);
      last_vs_s = int'(s_vs);
      last_fs_s = int'(s_fs);
   endtask

   // One clock: drive, check the pre-edge state, then advance the model with the edge.
   task automatic tick(input bit pe, input bit rs);
      @(negedge clk);
      pix_en  = pe;
      restart = rs;
      #1;
      check_all(pe);
      @(posedge clk);
      if (rs) begin
         m_pos_b = 0; m_fs_b = 1;
         m_pos_s = 0; m_fs_s = 1;
      end else if (pe) begin
         m_pos_b = (m_pos_b + 1) % (B_HT * B_VT); m_fs_b = (m_pos_b == 0);
         m_pos_s = (m_pos_s + 1) % (S_HT * S_VT); m_fs_s = (m_pos_s == 0);
      end else begin
         m_fs_b = 0;
         m_fs_s = 0;
      end
   endtask

   // Assert reset away from any clock edge and check it acts without a clock.
   task automatic async_reset();
      @(negedge clk);
      pix_en  = 1'b0;
      restart = 1'b0;
      #2;
      rst_n = 1'b0;
      m_pos_b = 0; m_fs_b = 0;
      m_pos_s = 0; m_fs_s = 0;
      #1;
      check_all(1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit pe;
      bit rs;
      int h;
      int v;
      bit hs;
      bit de;
      bit fs;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int hs_cnt, de_fall, le_end, fs_cnt, vs_mask;

      // Big instance, starting from (0,0); hsync idles high.
      tbl[0] = '{pe: 1, rs: 0, h: 1, v: 0, hs: 1, de: 1, fs: 0};
      tbl[1] = '{pe: 0, rs: 0, h: 1, v: 0, hs: 1, de: 1, fs: 0};
      tbl[2] = '{pe: 1, rs: 0, h: 2, v: 0, hs: 1, de: 1, fs: 0};
      tbl[3] = '{pe: 0, rs: 0, h: 2, v: 0, hs: 1, de: 1, fs: 0};
      tbl[4] = '{pe: 1, rs: 0, h: 3, v: 0, hs: 1, de: 1, fs: 0};
      tbl[5] = '{pe: 0, rs: 1, h: 0, v: 0, hs: 1, de: 1, fs: 1};
      tbl[6] = '{pe: 0, rs: 0, h: 0, v: 0, hs: 1, de: 1, fs: 0};
      tbl[7] = '{pe: 1, rs: 1, h: 0, v: 0, hs: 1, de: 1, fs: 1};
      tbl[8] = '{pe: 1, rs: 0, h: 1, v: 0, hs: 1, de: 1, fs: 0};
      tbl[9] = '{pe: 1, rs: 0, h: 2, v: 0, hs: 1, de: 1, fs: 0};

      rst_n   = 1'b0;
      pix_en  = 1'b0;
      restart = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all(1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Advance to h=300 then reset asynchronously mid-cycle.
      repeat (300) tick(1'b1, 1'b0);
      async_reset();

      // Table: pix_en gating and restart priority.
      for (int i = 0; i < 10; i++) begin
         tick(tbl[i].pe, tbl[i].rs);
         #1;
         cmp($sformatf("tbl%0d_h", i), 32'(b_h), 32'(tbl[i].h));
         cmp($sformatf("tbl%0d_v", i), 32'(b_v), 32'(tbl[i].v));
         cmp($sformatf("tbl%0d_hsync", i), 32'(b_hs), 32'(tbl[i].hs));
         cmp($sformatf("tbl%0d_de", i), 32'(b_de), 32'(tbl[i].de));
         cmp($sformatf("tbl%0d_fs", i), 32'(b_fs), 32'(tbl[i].fs));
      end

      // Restart at (300,0) with pix_en low.
      repeat (298) tick(1'b1, 1'b0);
      cmp("pre_restart_h", 32'(last_h_b), 32'd299);
      tick(1'b0, 1'b1);
      #1;
      cmp("restart_h", 32'(b_h), 32'd0);
      cmp("restart_v", 32'(b_v), 32'd0);
      cmp("restart_fs", 32'(b_fs), 32'd1);
      cmp("restart_de", 32'(b_de), 32'd1);
      cmp("restart_hsync", 32'(b_hs), 32'd1);

      // One full line at constant pix_en.
      hs_cnt  = 0;
      de_fall = -1;
      le_end  = 0;
      for (int i = 0; i < B_HT; i++) begin
         tick(1'b1, 1'b0);
         if (last_hs_b == 0) hs_cnt++;
         if (last_de_b == 0 && de_fall < 0) de_fall = last_h_b;
         if (last_h_b == B_HT - 1) le_end = last_le_b;
      end
      #1;
      cmp("hsync_low_clks", 32'(hs_cnt), 32'd96);
      cmp("de_fall_h", 32'(de_fall), 32'd640);
      cmp("line_end_at_799", 32'(le_end), 32'd1);
      cmp("wrap_h", 32'(b_h), 32'd0);
      cmp("wrap_v", 32'(b_v), 32'd1);

      // Two full frames of the small instance.
      fs_cnt  = 0;
      vs_mask = 0;
      for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
         tick(1'b1, 1'b0);
         if (last_fs_s == 1) fs_cnt++;
         if (last_vs_s == 0) vs_mask |= (1 << last_v_s);
      end
      cmp("small_frame_starts", 32'(fs_cnt), 32'd2);
      cmp("small_vsync_lines", 32'(vs_mask), 32'h60);

      // Random pixel ticks, restarts and occasional async resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            async_reset();
         end else begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
